// File: rtl/retire_monitor.sv
// Retire monitor: counts retired instructions, traces retiring PCs into a FWFT FIFO and flags a stuck fetch PC.
// Define RETIRE_MONITOR_DATA_EN to also store commit data per trace entry.
module retire_monitor #(
    parameter int COMMIT_PORTS = 2,
    parameter int PC_W         = 32,
    parameter int DATA_W       = 32,
    parameter int HANG_CYCLES  = 500,
    parameter int TRACE_DEPTH  = 16
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [PC_W-1:0]                  pc_i,
    input  logic [COMMIT_PORTS-1:0]          commit_valid_i,
    input  logic [COMMIT_PORTS-1:0]          commit_flushed_i,
    input  logic [COMMIT_PORTS*PC_W-1:0]     commit_pc_i,
    input  logic [COMMIT_PORTS*DATA_W-1:0]   commit_data_i,
    output logic                             trace_valid_o,
    input  logic                             trace_ready_i,
    output logic [PC_W-1:0]                  trace_pc_o,
    output logic [DATA_W-1:0]                trace_data_o,
    output logic [$clog2(TRACE_DEPTH):0]     trace_level_o,
    output logic                             trace_overflow_o,
    output logic [63:0]                      commit_count_o,
    output logic                             hang_o
);

    // state    | meaning
    // S_IDLE   | no instruction retired yet since reset, stall counter held at 0
    // S_RUN    | watching pc_i for consecutive unchanged cycles
    // S_HUNG   | hang declared, terminal until reset
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_HUNG} state_t;

    localparam int AW = $clog2(TRACE_DEPTH);
    localparam int LW = AW + 1;
    localparam int NW = $clog2(COMMIT_PORTS + 1);
    localparam int CW = $clog2(HANG_CYCLES + 1);

    state_t              state;
    logic [CW-1:0]       stall_cnt;
    logic [PC_W-1:0]     last_pc;
    logic [AW-1:0]       wr_ptr;
    logic [AW-1:0]       rd_ptr;
    logic [PC_W-1:0]     pc_mem [TRACE_DEPTH];

    logic [COMMIT_PORTS-1:0] retire;
    logic [COMMIT_PORTS-1:0] accept;
    logic [NW-1:0]           rank [COMMIT_PORTS];
    logic [NW-1:0]           n_ret;
    logic [NW-1:0]           n_push;
    logic [LW-1:0]           space;
    logic                    pop;

    assign retire        = commit_valid_i & ~commit_flushed_i;
    assign trace_valid_o = (trace_level_o != '0);
    assign pop           = trace_valid_o & trace_ready_i;
    assign space         = LW'(TRACE_DEPTH) - trace_level_o;
    assign trace_pc_o    = pc_mem[rd_ptr];

    // Accepted entries are always a prefix of the retiring ports, so the slot is wr_ptr + rank.
    always_comb begin
        n_ret  = '0;
        n_push = '0;
        accept = '0;
        for (int k = 0; k < COMMIT_PORTS; k++) begin
            rank[k] = n_ret;
            if (retire[k]) begin
                n_ret = n_ret + NW'(1);
                if (LW'(rank[k]) < space) begin
                    accept[k] = 1'b1;
                    n_push    = n_push + NW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            for (int k = 0; k < COMMIT_PORTS; k++) begin
                if (accept[k]) pc_mem[wr_ptr + AW'(rank[k])] <= commit_pc_i[k*PC_W +: PC_W];
            end
        end
    end

`ifdef RETIRE_MONITOR_DATA_EN
    logic [DATA_W-1:0] data_mem [TRACE_DEPTH];

    always_ff @(posedge clk) begin
        if (rst_n) begin
            for (int k = 0; k < COMMIT_PORTS; k++) begin
                if (accept[k]) data_mem[wr_ptr + AW'(rank[k])] <= commit_data_i[k*DATA_W +: DATA_W];
            end
        end
    end

    assign trace_data_o = data_mem[rd_ptr];
`else
    logic unused_commit_data;
    assign unused_commit_data = ^commit_data_i;
    assign trace_data_o       = '0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr           <= '0;
            rd_ptr           <= '0;
            trace_level_o    <= '0;
            trace_overflow_o <= 1'b0;
            commit_count_o   <= '0;
        end else begin
            wr_ptr         <= wr_ptr + AW'(n_push);
            rd_ptr         <= rd_ptr + AW'(pop);
            trace_level_o  <= trace_level_o + LW'(n_push) - LW'(pop);
            commit_count_o <= commit_count_o + 64'(n_ret);
            if (n_ret != n_push) trace_overflow_o <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            stall_cnt <= '0;
            last_pc   <= '0;
            hang_o    <= 1'b0;
        end else begin
            last_pc <= pc_i;
            case (state)
                S_IDLE: begin
                    stall_cnt <= '0;
                    if (|retire) state <= S_RUN;
                end
                S_RUN: begin
                    if (stall_cnt == CW'(HANG_CYCLES)) begin
                        state  <= S_HUNG;
                        hang_o <= 1'b1;
                    end else if (pc_i == last_pc) begin
                        stall_cnt <= stall_cnt + CW'(1);
                    end else begin
                        stall_cnt <= '0;
                    end
                end
                S_HUNG: hang_o <= 1'b1;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/retire_monitor.md
RETIRE_MONITOR -- requirements
Module: retire_monitor

Interface
REQ-001 SHALL have parameter COMMIT_PORTS, default 2: number of retire ports observed per cycle (1..4).
REQ-002 SHALL have parameter PC_W, default 32: PC width.
REQ-003 SHALL have parameter DATA_W, default 32: commit data width.
REQ-004 SHALL have parameter HANG_CYCLES, default 500: consecutive unchanged-PC cycles that declare a hang (≥2).
REQ-005 SHALL have parameter TRACE_DEPTH, default 16: trace FIFO entries (power of 2, ≥COMMIT_PORTS).
REQ-006 SHALL have port clk  in  1: single clock; all state updates on the rising edge.
REQ-007 SHALL have port rst_n  in  1: reset, synchronous, active-low.
REQ-008 SHALL have port pc_i  in  PC_W: current fetch PC.
REQ-009 SHALL have port commit_valid_i  in  COMMIT_PORTS: per-port commit valid.
REQ-010 SHALL have port commit_flushed_i  in  COMMIT_PORTS: per-port flushed flag.
REQ-011 SHALL have port commit_pc_i  in  COMMIT_PORTS*PC_W: per-port PC, port 0 in the LSBs.
REQ-012 SHALL have port commit_data_i  in  COMMIT_PORTS*DATA_W: per-port writeback data.
REQ-013 SHALL have port trace_valid_o  out  1: trace FIFO non-empty.
REQ-014 SHALL have port trace_ready_i  in  1: consumer pops the head entry.
REQ-015 SHALL have port trace_pc_o  out  PC_W: PC of the head entry.
REQ-016 SHALL have port trace_data_o  out  DATA_W: data of the head entry.
REQ-017 SHALL have port trace_level_o  out  $clog2(TRACE_DEPTH)+1: FIFO occupancy.
REQ-018 SHALL have port trace_overflow_o  out  1: sticky flag, set when an entry was dropped.
REQ-019 SHALL have port commit_count_o  out  64: running count of retired instructions.
REQ-020 SHALL have port hang_o  out  1: sticky hang indication.

Function
REQ-021 A port retires when commit_valid_i[k] is 1 and commit_flushed_i[k] is 0; every other port state is ignored.
REQ-022 commit_count_o SHALL increase by the number of retiring ports in that cycle, one cycle later, and wrap modulo 2^64.
REQ-023 Retiring ports SHALL be pushed in ascending port order. Gaps are permitted: port 1 can retire while port 0 does not.
REQ-024 Pop SHALL occur when trace_valid_o and trace_ready_i are both 1. The head output SHALL be first-word-fall-through.
REQ-025 Push space SHALL be TRACE_DEPTH minus the current level; a pop in the same cycle does not free space for that cycle's pushes.
REQ-026 Retiring entries beyond the available space SHALL be dropped, highest port first. A drop sets trace_overflow_o on the next cycle. commit_count_o still counts dropped entries.
REQ-027 Pointers SHALL wrap modulo TRACE_DEPTH. trace_level_o equals level + pushes − pop.
REQ-028 Monitor FSM: IDLE → RUN on the first cycle containing any retiring port; RUN → HUNG when the stall counter equals HANG_CYCLES; HUNG is terminal until reset.
REQ-029 In IDLE the stall counter SHALL hold 0.
REQ-030 In RUN the counter SHALL increment when pc_i equals last_pc, otherwise clear to 0. last_pc SHALL load pc_i every cycle.
REQ-031 hang_o SHALL be 1 exactly in HUNG, asserting the cycle after the counter reaches HANG_CYCLES.
REQ-032 In HUNG, commits and trace operation SHALL continue unchanged.

Reset
REQ-033 When rst_n is 0 at a clock edge: FSM goes to IDLE; counter, last_pc, commit_count_o, FIFO pointers, trace_level_o, trace_overflow_o and hang_o go to 0; trace_valid_o goes to 0.
REQ-034 Reset mid-operation SHALL discard all FIFO contents. Inputs during reset cycles SHALL be ignored.

Configuration
REQ-035 Macro RETIRE_MONITOR_DATA_EN, when defined, SHALL store DATA_W data per entry and drive trace_data_o from the head entry.
REQ-036 When RETIRE_MONITOR_DATA_EN is undefined, no data storage SHALL exist and trace_data_o SHALL be constant 0; all other behaviour is identical.

Verification
REQ-037 Commit on both ports (PC 0x100 and 0x104), not flushed, trace_ready_i=0 → next cycle trace_level_o=2, head PC 0x100, commit_count_o=2.
REQ-038 Port 1 only, PC 0x200, with port 0 flushed → level +1, head PC 0x200, count +1.
REQ-039 Level 15 of 16, two retiring ports, pop asserted → port 0 entry stored, port 1 dropped, trace_overflow_o=1, level 15, count +2.
REQ-040 First commit, then pc_i held at 0x80 → hang_o=0 through the 500th unchanged cycle, 1 the following cycle. A PC change at unchanged cycle 499 clears the counter.
REQ-041 pc_i constant and no commits for 1000 cycles → FSM stays IDLE, hang_o=0.
REQ-042 Reset asserted with level 8, overflow 1, hang 1 → all outputs 0 the next cycle. Build without RETIRE_MONITOR_DATA_EN → trace_data_o=0 always.
